adder_16: RTL and testbench
===========================

ADDER_16 -- requirements
Module: adder_16

Interface
REQ-001 Parameters: none; datapath width fixed at 16 bits.
REQ-002 clk  input  1  single system clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  16  addend A, unsigned or two's-complement.
REQ-005 b  input  16  addend B, unsigned or two's-complement.
REQ-006 sum  output  16  registered low 16 bits of a+b.
REQ-007 cout  output  1  registered unsigned carry out of bit 15.
REQ-008 sign  output  1  registered sign flag, equal to sum[15].
REQ-009 parity  output  1  registered odd-parity flag, XOR of all 16 sum bits.
REQ-010 overflow  output  1  registered two's-complement overflow flag.

Function
REQ-011 The block SHALL compute the 17-bit result {cout,sum} = a + b, carry-in fixed at 0, with no truncation before bit 16.
REQ-012 The block SHALL sample a and b on every rising clk edge and present sum and all flags for that pair after the same edge: latency 1 cycle, throughput 1 result per cycle, no handshake.
REQ-013 sign SHALL equal bit 15 of the 16-bit sum.
REQ-014 parity SHALL be 1 when sum holds an odd number of 1 bits, 0 otherwise; parity SHALL be 0 for sum = 0x0000.
REQ-015 overflow SHALL be 1 exactly when a[15] = b[15] and sum[15] != a[15]; it SHALL be independent of cout.
REQ-016 Wrap-around: sums >= 0x10000 SHALL wrap modulo 2^16 with cout = 1.
REQ-017 All outputs SHALL change only on a rising clk edge or on reset assertion, and SHALL be glitch-free registered values.
REQ-018 The combinational adder path SHALL be a carry-lookahead structure: four 4-bit CLA groups with group generate/propagate combined by a second-level lookahead unit; a ripple chain of 16 full adders is not acceptable.

Reset
REQ-019 While rst_n = 0, sum SHALL be 0x0000 and cout, sign, parity and overflow SHALL be 0, taking effect immediately without a clock edge.
REQ-020 Reset asserted mid-operation SHALL discard the pending result; the first rising clk edge with rst_n = 1 SHALL register the result for the a, b present at that edge.
REQ-021 Reset deassertion SHALL be synchronised by the integrating design; the block adds no internal reset synchroniser.

Structure
REQ-022 A shared package SHALL hold the width constant (16), the CLA group width constant (4) and the group count (4).
REQ-023 One sub-module, cla_4, SHALL implement a 4-bit carry-lookahead group with ports a[3:0], b[3:0], cin, s[3:0], group generate, group propagate; adder_16 SHALL instantiate it four times.
REQ-024 The second-level lookahead, flag logic and output registers SHALL reside in adder_16.

Verification
REQ-025 a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, sign=0, parity=0, overflow=0.
REQ-026 a=0x8000, b=0x8000 -> sum=0x0000, cout=1, sign=0, parity=0, overflow=1.
REQ-027 a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, sign=1, parity=1, overflow=1.
REQ-028 a=0x1234, b=0x5678 -> sum=0x68AC, cout=0, sign=0, parity=1, overflow=0; a=0xABCD, b=0xEF01 -> sum=0x9ACE, cout=1, sign=1, parity=1, overflow=0.
REQ-029 Exhaustive sweep a, b in 0..15 -> sum = a+b each cycle, one cycle after sampling, cout=0, overflow=0.
REQ-030 Drive a=0xFFFF, b=0xFFFF, then pull rst_n low between clk edges -> all outputs 0 immediately. Release rst_n -> the next edge yields sum=0xFFFE, cout=1, sign=1, parity=1, overflow=0.

Source files
------------

// File: rtl/adder_16_pkg.sv
// Shared sizing for the 16-bit CLA adder: datapath width, CLA group width, group count.
package adder_16_pkg;
  localparam int WIDTH = 16;
  localparam int GRP_W = 4;
  localparam int N_GRP = WIDTH / GRP_W;
endpackage

// File: rtl/adder_16_cla_4.sv
// 4-bit carry-lookahead group: sum bits plus group generate/propagate for the next level.
// Purely combinational; no handshake.
module cla_4
  import adder_16_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             cin,
  output logic [GRP_W-1:0] s,
  output logic             g,
  output logic             p
);

  logic [GRP_W-1:0] bg;
  logic [GRP_W-1:0] bp;
  logic [GRP_W-1:0] c;

  assign bg = a & b;
  assign bp = a ^ b;

  // every internal carry is a flat sum of products of cin and the bit g/p terms
  assign c[0] = cin;
  assign c[1] = bg[0] | (bp[0] & cin);
  assign c[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & cin);
  assign c[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
              | (bp[2] & bp[1] & bp[0] & cin);

  assign s = bp ^ c;
  assign g = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
           | (bp[3] & bp[2] & bp[1] & bg[0]);
  assign p = &bp;

endmodule

// File: rtl/adder_16.sv
// Registered 16-bit two-level CLA adder with carry, sign, parity and overflow flags.
// Latency 1 cycle, one result per cycle; no backpressure.
module adder_16
  import adder_16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             sign,
  output logic             parity,
  output logic             overflow
);

  logic [WIDTH-1:0] sum_c;
  logic g0, g1, g2, g3;
  logic p0, p1, p2, p3;
  logic c1, c2, c3, c4;
  logic ovf_c;

  // group carries come from the second-level lookahead; carry-in to group 0 is 0
  assign c1 = g0;
  assign c2 = g1 | (p1 & g0);
  assign c3 = g2 | (p2 & g1) | (p2 & p1 & g0);
  assign c4 = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0);

  cla_4 u_cla0 (.a(a[0*GRP_W +: GRP_W]), .b(b[0*GRP_W +: GRP_W]), .cin(1'b0),
                .s(sum_c[0*GRP_W +: GRP_W]), .g(g0), .p(p0));
  cla_4 u_cla1 (.a(a[1*GRP_W +: GRP_W]), .b(b[1*GRP_W +: GRP_W]), .cin(c1),
                .s(sum_c[1*GRP_W +: GRP_W]), .g(g1), .p(p1));
  cla_4 u_cla2 (.a(a[2*GRP_W +: GRP_W]), .b(b[2*GRP_W +: GRP_W]), .cin(c2),
                .s(sum_c[2*GRP_W +: GRP_W]), .g(g2), .p(p2));
  cla_4 u_cla3 (.a(a[3*GRP_W +: GRP_W]), .b(b[3*GRP_W +: GRP_W]), .cin(c3),
                .s(sum_c[3*GRP_W +: GRP_W]), .g(g3), .p(p3));

  // signed overflow: like-signed operands producing an opposite-signed sum
  assign ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum      <= '0;
      cout     <= 1'b0;
      sign     <= 1'b0;
      parity   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sum      <= sum_c;
      cout     <= c4;
      sign     <= sum_c[WIDTH-1];
      parity   <= ^sum_c;
      overflow <= ovf_c;
    end
  end

endmodule

// File: tb/tb_adder_16.sv
// Directed checks of adder_16: reset values, corner vectors, small exhaustive sweep, mid-run reset.
module tb_adder_16;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] sum;
  logic        cout;
  logic        sign;
  logic        parity;
  logic        overflow;

  int n_chk;
  int n_err;

  adder_16 dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .sum(sum), .cout(cout), .sign(sign), .parity(parity), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_sum, input logic e_cout,
                         input logic e_sign, input logic e_par, input logic e_ovf);
    chk({tag, ".sum"},      sum,               e_sum);
    chk({tag, ".cout"},     {15'd0, cout},     {15'd0, e_cout});
    chk({tag, ".sign"},     {15'd0, sign},     {15'd0, e_sign});
    chk({tag, ".parity"},   {15'd0, parity},   {15'd0, e_par});
    chk({tag, ".overflow"}, {15'd0, overflow}, {15'd0, e_ovf});
  endtask

  // drive between edges, then look just after the capturing edge
  task automatic apply(input logic [15:0] va, input logic [15:0] vb);
    @(negedge clk);
    a = va;
    b = vb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] s;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    a = 16'h1234;
    b = 16'h5678;

    #2;
    chk_all("reset_pre_edge", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("reset_held", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    apply(16'hFFFF, 16'h0001); chk_all("ffff_p1",   16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(16'h8000, 16'h8000); chk_all("8000_8000", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    apply(16'h7FFF, 16'h0001); chk_all("7fff_p1",   16'h8000, 1'b0, 1'b1, 1'b1, 1'b1);
    apply(16'h1234, 16'h5678); chk_all("1234_5678", 16'h68AC, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(16'hABCD, 16'hEF01); chk_all("abcd_ef01", 16'h9ACE, 1'b1, 1'b1, 1'b1, 1'b0);
    apply(16'h0000, 16'h0000); chk_all("zero",      16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(16'h0FFF, 16'h0001); chk_all("grp_carry", 16'h1000, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(16'hC000, 16'hC000); chk_all("neg_noovf", 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        apply(16'(i), 16'(j));
        s = 16'(i + j);
        chk_all($sformatf("sweep_%0d_%0d", i, j), s, 1'b0, 1'b0, ^s, 1'b0);
      end
    end

    apply(16'hFFFF, 16'hFFFF);
    chk_all("ffff_ffff", 16'hFFFE, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("reset_hold_edge", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all("release_no_edge", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("post_release", 16'hFFFE, 1'b1, 1'b1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
